// File: rtl/stage1_and_2.sv
// rtl/stage1_and_2.sv - C-Pack front half: dictionary match/encode (stage 1) and line-fill control (stage 2)
module stage1_and_2 #(
   parameter int WIDTH      = 64,
   parameter int DICT_ENTRY = 16,
   parameter int DICT_WORD  = 32,
   parameter int WORD       = 32,
   parameter int CACHE_LINE = 128
) (
   input  logic                             i_clk,
   input  logic                             i_reset,
   input  logic [WIDTH-1:0]                 i_word,
   output logic [2:0]                       o_encoded1,
   output logic [2:0]                       o_encoded2,
   output logic [5:0]                       o_length1,
   output logic [5:0]                       o_length2,
   output logic [6:0]                       o_total_length,
   output logic                             o_store_flag,
   output logic [6:0]                       o_shift_amount,
   output logic                             o_send_back,
   output logic                             o_fill_flag,
   output logic                             o_output_flag,
   output logic                             o_fill_ctrl,
   output logic                             o_stop_flag,
   output logic [DICT_ENTRY*DICT_WORD-1:0]  dictionary_data
);

   localparam logic [2:0] CODE_ZZZZ = 3'b000;
   localparam logic [2:0] CODE_MMMM = 3'b001;
   localparam logic [2:0] CODE_ZZZX = 3'b010;
   localparam logic [2:0] CODE_MMMX = 3'b011;
   localparam logic [2:0] CODE_MMXX = 3'b100;
   localparam logic [2:0] CODE_XXXX = 3'b101;
   localparam int         IDX_W     = $clog2(DICT_ENTRY);

   // FIFO dictionary: packed so it maps straight onto dictionary_data
   logic [DICT_ENTRY-1:0][DICT_WORD-1:0] dict;
   logic [DICT_ENTRY-1:0]                dict_valid;
   logic [IDX_W-1:0]                     wr_ptr;
   logic [IDX_W-1:0]                     wr_ptr_w1;

   logic [WORD-1:0] word0;
   logic [WORD-1:0] word1;
   logic            hit_full0, hit_3b0, hit_2b0;
   logic            hit_full1, hit_3b1, hit_2b1;
   logic [2:0]      code0, code1;
   logic [5:0]      len0, len1;
   logic            push0, push1;

   // stage 2 line accumulator
   logic [6:0] acc;
   logic [6:0] acc_next;
   logic [7:0] line_sum;

   assign word0           = i_word[WORD-1:0];
   assign word1           = i_word[2*WORD-1:WORD];
   assign dictionary_data = dict;

   // Priority classification; match quality only matters, not which entry hit
   function automatic logic [8:0] classify(input logic [WORD-1:0] w, input logic full,
                                           input logic m3, input logic m2);
      if (w == '0)               return {CODE_ZZZZ, 6'd2};
      else if (w[WORD-1:8] == '0) return {CODE_ZZZX, 6'd12};
      else if (full)             return {CODE_MMMM, 6'd6};
      else if (m3)               return {CODE_MMMX, 6'd16};
      else if (m2)               return {CODE_MMXX, 6'd24};
      else                       return {CODE_XXXX, 6'd34};
   endfunction

   // Match both words against the pre-update dictionary; word1 also sees a forwarded word0 push
   always_comb begin
      hit_full0 = 1'b0;
      hit_3b0   = 1'b0;
      hit_2b0   = 1'b0;
      hit_full1 = 1'b0;
      hit_3b1   = 1'b0;
      hit_2b1   = 1'b0;
      for (int i = 0; i < DICT_ENTRY; i++) begin
         if (dict_valid[i]) begin
            hit_full0 = hit_full0 | (dict[i] == word0);
            hit_3b0   = hit_3b0   | (dict[i][DICT_WORD-1:8]  == word0[WORD-1:8]);
            hit_2b0   = hit_2b0   | (dict[i][DICT_WORD-1:16] == word0[WORD-1:16]);
            hit_full1 = hit_full1 | (dict[i] == word1);
            hit_3b1   = hit_3b1   | (dict[i][DICT_WORD-1:8]  == word1[WORD-1:8]);
            hit_2b1   = hit_2b1   | (dict[i][DICT_WORD-1:16] == word1[WORD-1:16]);
         end
      end
      {code0, len0} = classify(word0, hit_full0, hit_3b0, hit_2b0);
      push0 = (code0 == CODE_XXXX);
      if (push0) begin
         hit_full1 = hit_full1 | (word0 == word1);
         hit_3b1   = hit_3b1   | (word0[WORD-1:8]  == word1[WORD-1:8]);
         hit_2b1   = hit_2b1   | (word0[WORD-1:16] == word1[WORD-1:16]);
      end
      {code1, len1} = classify(word1, hit_full1, hit_3b1, hit_2b1);
      push1     = (code1 == CODE_XXXX);
      wr_ptr_w1 = push0 ? wr_ptr + IDX_W'(1) : wr_ptr;
   end

   // Push unmatched words at the write pointer, word0 first, oldest entry overwritten on wrap
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         dict       <= '0;
         dict_valid <= '0;
         wr_ptr     <= '0;
      end else begin
         if (push0) begin
            dict[wr_ptr]       <= word0;
            dict_valid[wr_ptr] <= 1'b1;
         end
         if (push1) begin
            dict[wr_ptr_w1]       <= word1;
            dict_valid[wr_ptr_w1] <= 1'b1;
         end
         wr_ptr <= wr_ptr + IDX_W'(push0) + IDX_W'(push1);
      end
   end

   // Stage-1 output registers: one-cycle latency from sampled pair to codes/lengths
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         o_encoded1 <= CODE_ZZZZ;
         o_encoded2 <= CODE_ZZZZ;
         o_length1  <= '0;
         o_length2  <= '0;
      end else begin
         o_encoded1 <= code0;
         o_encoded2 <= code1;
         o_length1  <= len0;
         o_length2  <= len1;
      end
   end

   // Stage 2: place the registered pair into the current line and decide close/spill
   always_comb begin
      o_total_length = {1'b0, o_length1} + {1'b0, o_length2};
      o_store_flag   = (o_total_length > 7'(WIDTH));
      o_shift_amount = acc;
      line_sum       = {1'b0, acc} + {1'b0, o_total_length};
      o_stop_flag    = 1'b0;
      o_fill_flag    = 1'b0;
      o_send_back    = 1'b0;
      o_output_flag  = 1'b0;
      acc_next       = line_sum[6:0];
      if (line_sum == 8'(CACHE_LINE)) begin
         o_output_flag = 1'b1;
         acc_next      = '0;
      end else if (line_sum > 8'(CACHE_LINE)) begin
         // pair does not fit: pad out this line and restart the pair at offset 0
         o_stop_flag   = 1'b1;
         o_fill_flag   = 1'b1;
         o_send_back   = 1'b1;
         o_output_flag = 1'b1;
         acc_next      = o_total_length;
      end
   end

   // Line fill level and delayed fill indication for the packer
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         acc         <= '0;
         o_fill_ctrl <= 1'b0;
      end else begin
         acc         <= acc_next;
         o_fill_ctrl <= o_fill_flag;
      end
   end

endmodule

// File: tb/tb_stage1_and_2.sv
// tb/tb_stage1_and_2.sv - scoreboard bench for stage1_and_2
module tb_stage1_and_2;

   logic         clk;
   logic         i_reset;
   logic [63:0]  i_word;
   logic [2:0]   o_encoded1, o_encoded2;
   logic [5:0]   o_length1, o_length2;
   logic [6:0]   o_total_length, o_shift_amount;
   logic         o_store_flag, o_send_back, o_fill_flag, o_output_flag, o_fill_ctrl, o_stop_flag;
   logic [511:0] dictionary_data;

   typedef struct packed {
      logic [2:0]  enc1;
      logic [2:0]  enc2;
      logic [5:0]  len1;
      logic [5:0]  len2;
      logic [6:0]  total;
      logic        store;
      logic [6:0]  shift;
      logic        ovf;
      logic        eq;
      logic        fctrl;
      logic        dchk;
      logic [8:0]  doff;
      logic [63:0] dval;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;
   logic in_valid = 1'b0;
   logic out_valid = 1'b0;

   stage1_and_2 dut (
      .i_clk           (clk),
      .i_reset         (i_reset),
      .i_word          (i_word),
      .o_encoded1      (o_encoded1),
      .o_encoded2      (o_encoded2),
      .o_length1       (o_length1),
      .o_length2       (o_length2),
      .o_total_length  (o_total_length),
      .o_store_flag    (o_store_flag),
      .o_shift_amount  (o_shift_amount),
      .o_send_back     (o_send_back),
      .o_fill_flag     (o_fill_flag),
      .o_output_flag   (o_output_flag),
      .o_fill_ctrl     (o_fill_ctrl),
      .o_stop_flag     (o_stop_flag),
      .dictionary_data (dictionary_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [2:0] e1, input logic [2:0] e2, input logic [5:0] l1,
                               input logic [5:0] l2, input logic [6:0] tot, input logic st,
                               input logic [6:0] sh, input logic ovf, input logic eq,
                               input logic fc);
      exp_t e;
      e.enc1 = e1; e.enc2 = e2; e.len1 = l1; e.len2 = l2; e.total = tot; e.store = st;
      e.shift = sh; e.ovf = ovf; e.eq = eq; e.fctrl = fc;
      e.dchk = 1'b0; e.doff = '0; e.dval = '0;
      return e;
   endfunction

   function automatic logic [31:0] wgen(input int n);
      logic [7:0] b;
      b = 8'(n);
      return {b + 8'h10, 8'h5A, 8'hC3, b};
   endfunction

   // expected response for the pair is pushed before the sampling edge
   task automatic drive(input logic [63:0] w, input exp_t e);
      i_word   = w;
      in_valid = 1'b1;
      q.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      i_reset = 1'b0;
      i_word  = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      i_reset = 1'b1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_enc1"}, 64'(o_encoded1), 64'd0);
      chk({tag, "_enc2"}, 64'(o_encoded2), 64'd0);
      chk({tag, "_len1"}, 64'(o_length1), 64'd0);
      chk({tag, "_len2"}, 64'(o_length2), 64'd0);
      chk({tag, "_total"}, 64'(o_total_length), 64'd0);
      chk({tag, "_shift"}, 64'(o_shift_amount), 64'd0);
      chk({tag, "_flags"},
          64'({o_store_flag, o_send_back, o_fill_flag, o_output_flag, o_fill_ctrl, o_stop_flag}),
          64'd0);
      chk({tag, "_dict_is_zero"}, 64'(dictionary_data == '0), 64'd1);
   endtask

   // 1-cycle latency marker for the monitor
   always @(posedge clk) out_valid <= in_valid;

   // monitor: compare the DUT's registered response against the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      if (out_valid) begin
         if (q.size() == 0) begin
            chk("sb_underflow", 64'd1, 64'd0);
         end else begin
            e = q.pop_front();
            chk("enc1", 64'(o_encoded1), 64'(e.enc1));
            chk("enc2", 64'(o_encoded2), 64'(e.enc2));
            chk("len1", 64'(o_length1), 64'(e.len1));
            chk("len2", 64'(o_length2), 64'(e.len2));
            chk("total", 64'(o_total_length), 64'(e.total));
            chk("store", 64'(o_store_flag), 64'(e.store));
            chk("shift", 64'(o_shift_amount), 64'(e.shift));
            chk("stop", 64'(o_stop_flag), 64'(e.ovf));
            chk("fill", 64'(o_fill_flag), 64'(e.ovf));
            chk("send_back", 64'(o_send_back), 64'(e.ovf));
            chk("output", 64'(o_output_flag), 64'(e.ovf | e.eq));
            chk("fill_ctrl", 64'(o_fill_ctrl), 64'(e.fctrl));
            if (e.dchk) chk("dict", dictionary_data[e.doff +: 64], e.dval);
         end
      end
   end

   initial begin
      exp_t e;
      i_reset = 1'b0;
      i_word  = '0;
      #1;
      chk_zero("reset");
      do_reset();

      // encode, match, zero, partial matches, overflow, forwarding, exact-fill
      e = mk(3'd5, 3'd5, 6'd34, 6'd34, 7'd68, 1'b1, 7'd0, 1'b0, 1'b0, 1'b0);
      e.dchk = 1'b1; e.doff = 9'd0; e.dval = 64'h11223344_AABBCCDD;
      drive({32'h11223344, 32'hAABBCCDD}, e);
      drive({32'h11223344, 32'hAABBCCDD}, mk(3'd1, 3'd1, 6'd6, 6'd6, 7'd12, 1'b0, 7'd68, 1'b0, 1'b0, 1'b0));
      drive({32'h00000000, 32'h00000000}, mk(3'd0, 3'd0, 6'd2, 6'd2, 7'd4, 1'b0, 7'd80, 1'b0, 1'b0, 1'b0));
      drive({32'h000000FF, 32'hAABBCC11}, mk(3'd3, 3'd2, 6'd16, 6'd12, 7'd28, 1'b0, 7'd84, 1'b0, 1'b0, 1'b0));
      drive({32'h11223344, 32'h1122FFFF}, mk(3'd4, 3'd1, 6'd24, 6'd6, 7'd30, 1'b0, 7'd112, 1'b1, 1'b0, 1'b0));
      drive({32'h00000000, 32'h00000000}, mk(3'd0, 3'd0, 6'd2, 6'd2, 7'd4, 1'b0, 7'd30, 1'b0, 1'b0, 1'b1));
      e = mk(3'd5, 3'd3, 6'd34, 6'd16, 7'd50, 1'b0, 7'd34, 1'b0, 1'b0, 1'b0);
      e.dchk = 1'b1; e.doff = 9'd64; e.dval = 64'h00000000_DEADBEEF;
      drive({32'hDEADBE00, 32'hDEADBEEF}, e);
      drive({32'hDEADBEEF, 32'hDEADBEEF}, mk(3'd1, 3'd1, 6'd6, 6'd6, 7'd12, 1'b0, 7'd84, 1'b0, 1'b0, 1'b0));
      drive({32'hDEADBE22, 32'hDEADBE11}, mk(3'd3, 3'd3, 6'd16, 6'd16, 7'd32, 1'b0, 7'd96, 1'b0, 1'b1, 1'b0));
      drive({32'h00000000, 32'h00000000}, mk(3'd0, 3'd0, 6'd2, 6'd2, 7'd4, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0));

      // two literal pairs overflow the line
      do_reset();
      drive({32'h01010101, 32'h02020202}, mk(3'd5, 3'd5, 6'd34, 6'd34, 7'd68, 1'b1, 7'd0, 1'b0, 1'b0, 1'b0));
      drive({32'h03030303, 32'h04040404}, mk(3'd5, 3'd5, 6'd34, 6'd34, 7'd68, 1'b1, 7'd68, 1'b1, 1'b0, 1'b0));
      drive({32'h00000000, 32'h00000000}, mk(3'd0, 3'd0, 6'd2, 6'd2, 7'd4, 1'b0, 7'd68, 1'b0, 1'b0, 1'b1));

      // dictionary wrap: 18 distinct literals, entries 0/1 overwritten
      do_reset();
      for (int n = 0; n < 9; n++) begin
         e = mk(3'd5, 3'd5, 6'd34, 6'd34, 7'd68, 1'b1, (n == 0) ? 7'd0 : 7'd68,
                n > 0, 1'b0, n > 1);
         if (n == 8) begin
            e.dchk = 1'b1; e.doff = 9'd0; e.dval = {wgen(17), wgen(16)};
         end
         drive({wgen(2 * n + 1), wgen(2 * n)}, e);
      end
      drive({32'h00000000, wgen(0)}, mk(3'd5, 3'd0, 6'd34, 6'd2, 7'd36, 1'b0, 7'd68, 1'b0, 1'b0, 1'b1));

      // asynchronous reset mid-cycle clears everything before the next edge
      repeat (2) @(posedge clk);
      #3;
      i_reset = 1'b0;
      #1;
      chk_zero("async_reset");
      #2;
      i_reset = 1'b1;
      repeat (2) @(posedge clk);

      chk("sb_drained", 64'(q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
